// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared widths, shift codes and fetch states for the datapath
//
// Purpose: constants and types shared by the operand-fetch stage, its register
//          file and the downstream shifter.
// Contents:
//   DATA_W        operand/register width
//   NREGS         register count
//   REG_AW        register index width, derived from NREGS
//   shift_op_t    shift code presented to the shifter
//   fetch_state_t operand-fetch sequencer states
package datapath_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    HOLD   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/operand_fetch_regfile.sv
// rtl/operand_fetch_regfile.sv - NREGS x DATA_W register file, sync write, async read
//
// Purpose: operand storage for the fetch stage; written from the C register.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high; clears every register, beats a write
//   wr_en    in   write enable
//   wr_num   in   write register index
//   wr_data  in   write data
//   rd_num   in   read register index
//   rd_data  out  combinational read data
module operand_fetch_regfile
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_num,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_num] <= wr_data;
    end
  end

  assign rd_data = regs[rd_num];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - sequenced A/B operand fetch with valid/ready hold toward the shifter
//
// Purpose: on start, reads operand A then operand B from the register file
//          through its single read port, latches them with the shift code and
//          holds them valid until the downstream stage accepts.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high
//   wr_en        in   writeback enable
//   wr_num       in   writeback register index
//   wr_data      in   writeback data
//   start        in   fetch request, sampled only in IDLE
//   rd_num_a     in   A source register, captured on accepted start
//   rd_num_b     in   B source register, captured on accepted start
//   shift_op_in  in   shift code, captured on accepted start
//   busy         out  sequencer not idle
//   out_valid    out  a_out/b_out/shift_op valid (HOLD)
//   out_ready    in   downstream consumes, sampled only in HOLD
//   a_out        out  latched A operand (to ALU)
//   b_out        out  latched B operand (to shifter shift_in)
//   shift_op     out  latched shift code (to shifter shift_op)
module operand_fetch
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [REG_AW-1:0] rd_num_a,
  input  logic [REG_AW-1:0] rd_num_b,
  input  logic [1:0]        shift_op_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_op
);

  fetch_state_t      state, next_state;
  logic [REG_AW-1:0] req_a, req_b;
  shift_op_t         req_op;
  logic [REG_AW-1:0] rd_num;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] fetch_data;

  operand_fetch_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .rd_num  (rd_num),
    .rd_data (rd_data)
  );

  // The single read port is steered by the sequencer; a write landing on the
  // same edge to the register being read is forwarded so the latch never
  // captures the stale value.
  assign rd_num     = (state == READ_A) ? req_a : req_b;
  assign fetch_data = (wr_en && (wr_num == rd_num)) ? wr_data : rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = READ_A;
      end
      READ_A: next_state = READ_B;
      READ_B: next_state = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request registers load only on an accepted start, so a start pulse seen
  // mid-fetch cannot disturb the operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_a  <= '0;
      req_b  <= '0;
      req_op <= SH_NONE;
    end else if (state == IDLE && start) begin
      req_a  <= rd_num_a;
      req_b  <= rd_num_b;
      req_op <= shift_op_t'(shift_op_in);
    end
  end

  // Output latches update only in READ_A/READ_B, which is what keeps them
  // frozen through HOLD and IDLE regardless of later writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out    <= '0;
      b_out    <= '0;
      shift_op <= 2'b00;
    end else if (state == READ_A) begin
      a_out <= fetch_data;
    end else if (state == READ_B) begin
      b_out    <= fetch_data;
      shift_op <= req_op;
    end
  end

endmodule
